// File: rtl/r8_pp_select_if.sv
// Operand/partial-product stream bundle for the radix-8 Booth selector.
// master = upstream/downstream environment, slave = the selector itself.
interface r8_pp_select_if #(parameter int N = 24);
  logic           in_valid;
  logic           in_ready;
  logic [N+2:0]   x_1;
  logic [N+2:0]   x_2;
  logic [N+2:0]   x_3;
  logic [N+2:0]   x_4;
  logic [N-1:0]   y_in;
  logic           out_valid;
  logic           out_ready;
  logic [N+3:0]   pp_out;
  logic           pp_neg;
  logic [3:0]     pp_idx;
  logic           pp_last;

  modport master (
    output in_valid, x_1, x_2, x_3, x_4, y_in, out_ready,
    input  in_ready, out_valid, pp_out, pp_neg, pp_idx, pp_last
  );

  modport slave (
    input  in_valid, x_1, x_2, x_3, x_4, y_in, out_ready,
    output in_ready, out_valid, pp_out, pp_neg, pp_idx, pp_last
  );
endinterface

// File: rtl/r8_pp_select.sv
// Radix-8 modified-Booth partial-product selector: latches one operand set and
// streams the G recoded partial products, one per accepted beat.
module r8_pp_select #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  r8_pp_select_if.slave  bus
);
  localparam int         G    = N / 3 + 1;
  localparam int         W    = N + 4;
  localparam logic [3:0] LAST = 4'(G - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, nxt;
  logic [3:0]   idx;
  logic [N+2:0] x1r, x2r, x3r, x4r;
  logic [N-1:0] yr;
  logic         in_rdy, out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      x1r   <= '0;
      x2r   <= '0;
      x3r   <= '0;
      x4r   <= '0;
      yr    <= '0;
    end else begin
      state <= nxt;
      if (bus.in_valid && in_rdy) begin
        x1r <= bus.x_1;
        x2r <= bus.x_2;
        x3r <= bus.x_3;
        x4r <= bus.x_4;
        yr  <= bus.y_in;
        idx <= '0;
      end else if (out_vld && bus.out_ready) begin
        idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  always_comb begin
    nxt     = state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = !rst;
        if (bus.in_valid && !rst) nxt = RUN;
      end
      RUN: begin
        out_vld = !rst;
        if (bus.out_ready && idx == LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // y extended with y[-1]=0 below and zeros above, so digit i is yx[3i+3:3i].
  logic [W-1:0] yx;
  logic [3:0]   dig;
  logic [2:0]   sel;
  logic         neg;
  logic [W-1:0] mag, pp;

  assign yx  = {3'b000, yr, 1'b0};
  assign dig = 4'(yx >> (3 * idx));

  always_comb begin
    sel = 3'd0;
    neg = 1'b0;
    unique case (dig)
      4'b0000, 4'b1111: begin sel = 3'd0; neg = 1'b0; end
      4'b0001, 4'b0010: begin sel = 3'd1; neg = 1'b0; end
      4'b0011, 4'b0100: begin sel = 3'd2; neg = 1'b0; end
      4'b0101, 4'b0110: begin sel = 3'd3; neg = 1'b0; end
      4'b0111:          begin sel = 3'd4; neg = 1'b0; end
      4'b1000:          begin sel = 3'd4; neg = 1'b1; end
      4'b1001, 4'b1010: begin sel = 3'd3; neg = 1'b1; end
      4'b1011, 4'b1100: begin sel = 3'd2; neg = 1'b1; end
      4'b1101, 4'b1110: begin sel = 3'd1; neg = 1'b1; end
      default:          begin sel = 3'd0; neg = 1'b0; end
    endcase
  end

  always_comb begin
    mag = '0;
    unique case (sel)
      3'd1:    mag = {1'b0, x1r};
      3'd2:    mag = {1'b0, x2r};
      3'd3:    mag = {1'b0, x3r};
      3'd4:    mag = {1'b0, x4r};
      default: mag = '0;
    endcase
  end

  assign pp = neg ? ~mag : mag;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.pp_out    = out_vld ? pp  : '0;
  assign bus.pp_neg    = out_vld & neg;
  assign bus.pp_idx    = out_vld ? idx : 4'd0;
  assign bus.pp_last   = out_vld && (idx == LAST);
endmodule

// File: tb/tb_r8_pp_select.sv
// Scoreboarded bench for r8_pp_select: directed beat checks plus product-sum checks.
module tb_r8_pp_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r8_pp_select_if #(.N(24)) bus();
  r8_pp_select #(.N(24)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [27:0] pp;
    logic        neg;
    logic        chk;
  } beat_t;

  beat_t       beat_q[$];
  logic [51:0] prod_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: beats are consumed at the negedge preceding the accepting posedge.
  int          mi  = 0;
  logic [51:0] acc = '0;
  beat_t       mb;
  always @(negedge clk) begin
    if (rst) begin
      mi  = 0;
      acc = '0;
    end else if (bus.out_valid && bus.out_ready) begin
      chk("pp_idx", 64'(bus.pp_idx), 64'(mi));
      chk("pp_last", 64'(bus.pp_last), 64'(mi == 8));
      if (beat_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: got idx %0d expected no beat", bus.pp_idx);
      end else begin
        mb = beat_q.pop_front();
        if (mb.chk) begin
          chk("pp_out", 64'(bus.pp_out), 64'(mb.pp));
          chk("pp_neg", 64'(bus.pp_neg), 64'(mb.neg));
        end
      end
      // Negative rows carry a set top bit, so sign-extend before weighting.
      acc = acc + (({{24{bus.pp_out[27]}}, bus.pp_out} + 52'(bus.pp_neg)) << (3 * mi));
      if (mi == 8) begin
        if (prod_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_op: got sum %0h expected no operation", acc);
        end else begin
          chk("product_sum", 64'(acc), 64'(prod_q.pop_front()));
        end
        mi  = 0;
        acc = '0;
      end else begin
        mi++;
      end
    end
  end

  task automatic issue(input logic [23:0] x1, input logic [23:0] y, input logic c,
                       input logic [27:0] p0, input logic n0,
                       input logic [27:0] p1, input logic n1,
                       input logic [27:0] p8, input logic n8);
    int    k = 0;
    beat_t b;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    for (int i = 0; i < 9; i++) begin
      b.chk = c;
      b.pp  = (i == 0) ? p0 : (i == 1) ? p1 : (i == 8) ? p8 : 28'd0;
      b.neg = (i == 0) ? n0 : (i == 1) ? n1 : (i == 8) ? n8 : 1'b0;
      beat_q.push_back(b);
    end
    prod_q.push_back(52'(x1) * 52'(y));
    bus.x_1      = {3'b000, x1};
    bus.x_2      = {2'b00, x1, 1'b0};
    bus.x_3      = {3'b000, x1} + {2'b00, x1, 1'b0};
    bus.x_4      = {1'b0, x1, 2'b00};
    bus.y_in     = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("first_out_valid", 64'(bus.out_valid), 64'd1);
    chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (beat_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (beat_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", beat_q.size());
      beat_q.delete();
      prod_q.delete();
    end
    @(posedge clk);
    #1 chk("in_ready_after", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int k = 0;
    while (bus.pp_idx != target && k < 30) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reach_idx", 64'(bus.pp_idx), 64'(target));
  endtask

  logic [27:0] s_pp;
  logic        s_neg, s_last;
  logic [3:0]  s_idx;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x_1 = '0; bus.x_2 = '0; bus.x_3 = '0; bus.x_4 = '0; bus.y_in = '0;

    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pp_out", 64'(bus.pp_out), 64'd0);
    chk("rst_pp_last", 64'(bus.pp_last), 64'd0);
    rst = 1'b0;
    #1 chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed digit patterns.
    issue(24'd5, 24'h000001, 1'b1, 28'd5, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0);
    drain();
    issue(24'd5, 24'h000007, 1'b1, ~28'd5, 1'b1, 28'd5, 1'b0, 28'd0, 1'b0);
    drain();
    issue(24'd5, 24'h000004, 1'b1, ~28'd20, 1'b1, 28'd5, 1'b0, 28'd0, 1'b0);
    drain();
    issue(24'd5, 24'h000003, 1'b1, 28'd15, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0);
    drain();
    issue(24'd1, 24'hFFFFFF, 1'b1, ~28'd1, 1'b1, 28'd0, 1'b0, 28'd1, 1'b0);
    drain();

    // Backpressure at idx 2, with an in_valid pulse that must be ignored.
    issue(24'h123456, 24'hABCDEF, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0);
    wait_idx(4'd2);
    bus.out_ready = 1'b0;
    s_pp = bus.pp_out; s_neg = bus.pp_neg; s_idx = bus.pp_idx; s_last = bus.pp_last;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.in_valid = 1'b1;
        bus.x_1 = 27'h7FFFFFF; bus.y_in = 24'h55AA55;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk("bp_pp_out", 64'(bus.pp_out), 64'(s_pp));
      chk("bp_pp_neg", 64'(bus.pp_neg), 64'(s_neg));
      chk("bp_pp_idx", 64'(bus.pp_idx), 64'(s_idx));
      chk("bp_pp_last", 64'(bus.pp_last), 64'(s_last));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of an operation.
    issue(24'd5, 24'h000007, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0);
    wait_idx(4'd4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_pp_out", 64'(bus.pp_out), 64'd0);
    chk("midrst_pp_last", 64'(bus.pp_last), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    beat_q.delete();
    prod_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    issue(24'd5, 24'h000007, 1'b1, ~28'd5, 1'b1, 28'd5, 1'b0, 28'd0, 1'b0);
    drain();

    // Random operands, checked through the weighted product sum.
    for (int r = 0; r < 200; r++) begin
      issue(24'($urandom), 24'($urandom), 1'b0, 28'd0, 1'b0, 28'd0, 1'b0, 28'd0, 1'b0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/r8_pp_select.md
Name: r8_pp_select

Overview:
- Radix-8 modified-Booth partial-product selector for the R8 MBE multiplier.
- Sits directly downstream of the multiplicand-multiples generator. Consumes its four 27-bit multiples (1X, 2X, 3X, 4X) together with the 24-bit unsigned multiplier operand.
- Serially emits the 9 Booth-recoded partial products, one per accepted beat, over a valid/ready stream to the Dadda reduction and accumulation stage.

Parameters:
- N, 24, multiplier/multiplicand width (unsigned).
- G, N/3+1 (=9), number of radix-8 digits; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- x_1  in  N+3  1X multiple.
- x_2  in  N+3  2X multiple.
- x_3  in  N+3  3X multiple.
- x_4  in  N+3  4X multiple.
- y_in  in  N  multiplier operand.
- out_valid  out  1  partial product valid.
- out_ready  in  1  downstream accepts the partial product.
- pp_out  out  N+4  selected partial product, one's-complemented when negative.
- pp_neg  out  1  negate flag; downstream injects +1 at the LSB of this row.
- pp_idx  out  4  digit index 0..G-1; row weight is 8^pp_idx.
- pp_last  out  1  high with pp_idx==G-1.

Behaviour:
- Reset: rst (async) forces state IDLE. While rst is high, in_ready, out_valid, pp_out, pp_neg, pp_idx and pp_last are all 0. The captured operand registers clear to 0.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&&in_ready latches x_1..x_4 and y_in, sets idx=0 and moves to RUN.
- FSM RUN:
  - in_ready=0; in_valid is ignored and the captured operands are unaffected.
  - out_valid=1.
  - On out_valid&&out_ready with idx<G-1: idx<=idx+1.
  - On that handshake with idx==G-1: go to IDLE.
- Latency and throughput: input handshake at edge k gives first out_valid after edge k. One operand set takes G+1 cycles minimum (G output beats plus 1 IDLE cycle).
- Stability: while out_valid&&!out_ready, pp_out, pp_neg, pp_idx and pp_last hold constant.
- When out_valid=0, pp_out, pp_neg, pp_idx and pp_last are driven 0.
- Digit recoding:
  - Bits used: b3=y[3i+2], b2=y[3i+1], b1=y[3i], b0=y[3i-1].
  - y[-1]=0, and y[j]=0 for j>=N (unsigned extension).
  - d = -4*b3 + 2*b2 + b1 + b0, with d in -4..4.
- Magnitude select: |d| = 0,1,2,3,4 selects 0, x_1, x_2, x_3, x_4. mag is zero-extended to N+4 bits.
- Negative digits: pp_neg = (d<0). pp_out = pp_neg ? ~mag : mag (full N+4-bit inversion).
- Digit 0: d=0 gives pp_out=0 and pp_neg=0, including pattern 1111 ("-0" never asserts neg).
- Last digit: digit G-1 uses b0=y[N-1] with upper bits 0, so it is always 0 or +1.
- Arithmetic invariant: sum over i of (pp_out_i + pp_neg_i)·8^i, taken mod 2^(3G+N+1), equals x_1·y_in. The bench uses this as its scoreboard check.
- pp_last = out_valid && idx==G-1.
- Reset mid-RUN: the operation is abandoned, with no further beats and no pp_last. The next accepted operand set starts again at idx 0.

Test Plan:
- Positive digit: x_1=5 (x_2=10, x_3=15, x_4=20), y_in=0x000001, out_ready=1 -> 9 beats. Beat 0: pp_out=5, neg=0. Beats 1..8: pp_out=0, neg=0. pp_last only on idx 8. in_ready returns 1 the cycle after.
- Negative digit: x_1=5, y_in=0x000007 -> beat0 pp_out=~28'd5, neg=1. beat1 pp_out=5, neg=0. Rest 0. Scoreboard sum mod 2^52 = 35.
- 4X and 3X select: y_in=0x000004 gives beat0 ~x_4 (~20), neg=1, then beat1 5. y_in=0x000003 gives beat0 x_3=15, neg=0.
- All-ones: x_1=1, y_in=0xFFFFFF -> beat0 ~1 with neg=1; beats 1..7 pp_out=0 with neg=0; beat8 pp_out=1, neg=0. Scoreboard sum = 0xFFFFFF. Repeat with 200 random x_1/y_in pairs against x_1·y_in.
- Backpressure: drop out_ready for 3 cycles at idx 2 -> all outputs stable, idx held. in_valid pulsed during RUN is ignored (in_ready=0).
- Reset mid-op: assert rst asynchronously at idx 4 -> out_valid=0 immediately. After release in_ready=1; a new operand set starts at idx 0 with correct results.
